// File: rtl/fpu_mc_pkg.sv
// Shared types and latency helpers for the multi-cycle FPU issue/completion scheduler.
package fpu_mc_pkg;

    typedef enum logic [1:0] {
        OP_FMUL  = 2'd0,
        OP_FDIV  = 2'd1,
        OP_FSQRT = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    localparam int LAT_MUL_D  = 2;
    localparam int LAT_DIV_D  = 8;
    localparam int LAT_SQRT_D = 5;

    // One writeback-port reservation: the result is sampled when the entry reaches index 0.
    typedef struct packed {
        logic       valid;
        logic [1:0] op;
        logic [4:0] rd;
        logic       fmode;
    } res_entry_t;

    function automatic int lat_of(logic [1:0] op, int lat_mul, int lat_div, int lat_sqrt);
        case (op)
            OP_FMUL:  lat_of = lat_mul;
            OP_FDIV:  lat_of = lat_div;
            OP_FSQRT: lat_of = lat_sqrt;
            default:  lat_of = 0;
        endcase
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

    localparam int LMAX = max3(LAT_MUL_D, LAT_DIV_D, LAT_SQRT_D);

endpackage

// File: rtl/fpu_mc_scoreboard.sv
// Destination-register busy bits for the int (fmode=0) and float (fmode=1) files,
// with query masking so a consumer can bypass from the writeback in the same cycle.
module fpu_mc_scoreboard
    import fpu_mc_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_rd,
    input  logic       set_fmode,
    input  logic       clr_en,
    input  logic [4:0] clr_rd,
    input  logic       clr_fmode,
    input  logic [4:0] q_rs,
    input  logic       q_fm1,
    input  logic [4:0] q_rt,
    input  logic       q_fm2,
    input  logic [4:0] q_rd,
    input  logic       q_fm3,
    output logic       hazard,
    output logic       rd_busy
);

    logic [1:0][NREG-1:0] busy;

    function automatic logic pending(logic [1:0][NREG-1:0] b, logic [4:0] rd, logic fm,
                                     logic w_en, logic [4:0] w_rd, logic w_fm);
        pending = b[fm][rd] && !(fm == 1'b0 && rd == 5'd0) &&
                  !(w_en && w_rd == rd && w_fm == fm);
    endfunction

    // The set is the later assignment, so it wins over a clear of the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en)
                busy[clr_fmode][clr_rd] <= 1'b0;
            if (set_en && !(set_fmode == 1'b0 && set_rd == 5'd0))
                busy[set_fmode][set_rd] <= 1'b1;
        end
    end

    assign hazard  = pending(busy, q_rs, q_fm1, clr_en, clr_rd, clr_fmode) |
                     pending(busy, q_rt, q_fm2, clr_en, clr_rd, clr_fmode);
    assign rd_busy = pending(busy, q_rd, q_fm3, clr_en, clr_rd, clr_fmode);

endmodule

// File: rtl/fpu_mc_sched.sv
// Issue/completion scheduler for pipelined FMUL/FDIV/FSQRT units sharing one writeback port.
// Valid/ready: an op is issued in a cycle where in_valid & in_ready; in_valid must not depend on in_ready.
module fpu_mc_sched
    import fpu_mc_pkg::*;
#(
    parameter int DW       = 32,
    parameter int LAT_MUL  = LAT_MUL_D,
    parameter int LAT_DIV  = LAT_DIV_D,
    parameter int LAT_SQRT = LAT_SQRT_D,
    parameter int NREG     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [4:0]    in_rd,
    input  logic          in_fmode,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          mul_start,
    output logic          div_start,
    output logic          sqrt_start,
    output logic [DW-1:0] fu_a,
    output logic [DW-1:0] fu_b,
    input  logic [DW-1:0] mul_res,
    input  logic [DW-1:0] div_res,
    input  logic [DW-1:0] sqrt_res,
    output logic          wb_valid,
    output logic [4:0]    wb_rd,
    output logic          wb_fmode,
    output logic [DW-1:0] wb_data,
    input  logic [4:0]    q_rs,
    input  logic [4:0]    q_rt,
    input  logic          q_fm1,
    input  logic          q_fm2,
    output logic          hazard,
    output logic          idle
);

    localparam int DEPTH = max3(LAT_MUL, LAT_DIV, LAT_SQRT);

    res_entry_t [DEPTH-1:0] tbl;
    res_entry_t [DEPTH-1:0] tbl_nxt;
    res_entry_t             new_entry;
    int                     lat;
    logic                   slot_busy;
    logic                   any_valid;
    logic                   dest_busy;
    logic                   accept;
    logic [DW-1:0]          res_sel;

    // Index k holds the op whose result is sampled k cycles from now.
    always_comb begin
        lat       = lat_of(in_op, LAT_MUL, LAT_DIV, LAT_SQRT);
        slot_busy = 1'b0;
        any_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == lat && tbl[k].valid)
                slot_busy = 1'b1;
            if (tbl[k].valid)
                any_valid = 1'b1;
        end
    end

    assign in_ready   = ~rst & (in_op != OP_RSVD) & ~slot_busy & ~dest_busy;
    assign accept     = in_valid & in_ready;
    assign mul_start  = accept & (in_op == OP_FMUL);
    assign div_start  = accept & (in_op == OP_FDIV);
    assign sqrt_start = accept & (in_op == OP_FSQRT);
    assign fu_a       = in_a;
    assign fu_b       = in_b;

    assign new_entry = '{valid: 1'b1, op: in_op, rd: in_rd, fmode: in_fmode};

    always_comb begin
        tbl_nxt = tbl >> $bits(res_entry_t);
        for (int k = 0; k < DEPTH; k++) begin
            if (accept && k == lat - 1)
                tbl_nxt[k] = new_entry;
        end
    end

    always_comb begin
        case (tbl[0].op)
            OP_FDIV:  res_sel = div_res;
            OP_FSQRT: res_sel = sqrt_res;
            default:  res_sel = mul_res;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl      <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_fmode <= 1'b0;
            wb_data  <= '0;
        end else begin
            tbl      <= tbl_nxt;
            wb_valid <= tbl[0].valid;
            if (tbl[0].valid) begin
                wb_rd    <= tbl[0].rd;
                wb_fmode <= tbl[0].fmode;
                wb_data  <= res_sel;
            end
        end
    end

    assign idle = ~any_valid & ~wb_valid;

    fpu_mc_scoreboard #(.NREG(NREG)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (accept),
        .set_rd    (in_rd),
        .set_fmode (in_fmode),
        .clr_en    (wb_valid),
        .clr_rd    (wb_rd),
        .clr_fmode (wb_fmode),
        .q_rs      (q_rs),
        .q_fm1     (q_fm1),
        .q_rt      (q_rt),
        .q_fm2     (q_fm2),
        .q_rd      (in_rd),
        .q_fm3     (in_fmode),
        .hazard    (hazard),
        .rd_busy   (dest_busy)
    );

endmodule
